// File: rtl/nasti_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : nasti_stream_arbiter
// Brief    : Packet-level round-robin arbiter folding N lane-indexed stream
//            ports onto one registered stream output.
// Revision : 1.0
// ============================================================================
module nasti_stream_arbiter #(
    parameter  int N_PORT     = 4,
    parameter  int DATA_WIDTH = 64,
    parameter  int ID_WIDTH   = 8,
    parameter  int DEST_WIDTH = 4,
    parameter  int USER_WIDTH = 8,
    localparam int IDX_W      = (N_PORT > 1) ? $clog2(N_PORT) : 1,
    localparam int STRB_W     = DATA_WIDTH / 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [N_PORT-1:0]              port_en_i,
    input  logic [N_PORT-1:0]              s_valid_i,
    output logic [N_PORT-1:0]              s_ready_o,
    input  logic [N_PORT*DATA_WIDTH-1:0]   s_data_i,
    input  logic [N_PORT*STRB_W-1:0]       s_strb_i,
    input  logic [N_PORT*STRB_W-1:0]       s_keep_i,
    input  logic [N_PORT-1:0]              s_last_i,
    input  logic [N_PORT*ID_WIDTH-1:0]     s_id_i,
    input  logic [N_PORT*DEST_WIDTH-1:0]   s_dest_i,
    input  logic [N_PORT*USER_WIDTH-1:0]   s_user_i,
    output logic                           m_valid_o,
    input  logic                           m_ready_i,
    output logic [DATA_WIDTH-1:0]          m_data_o,
    output logic [STRB_W-1:0]              m_strb_o,
    output logic [STRB_W-1:0]              m_keep_o,
    output logic                           m_last_o,
    output logic [ID_WIDTH-1:0]            m_id_o,
    output logic [DEST_WIDTH-1:0]          m_dest_o,
    output logic [USER_WIDTH-1:0]          m_user_o,
    output logic [IDX_W-1:0]               grant_idx_o,
    output logic                           locked_o
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    localparam int               LANES_P2  = 1 << IDX_W;
    localparam logic [IDX_W-1:0] LAST_LANE = IDX_W'(N_PORT - 1);

    state_t                  state_q, state_d;
    // The round-robin pointer and the reported grant always move together.
    logic [IDX_W-1:0]        grant_q, grant_d;

    logic                    m_valid_q, m_valid_d;
    logic [DATA_WIDTH-1:0]   m_data_q;
    logic [STRB_W-1:0]       m_strb_q;
    logic [STRB_W-1:0]       m_keep_q;
    logic                    m_last_q;
    logic [ID_WIDTH-1:0]     m_id_q;
    logic [DEST_WIDTH-1:0]   m_dest_q;
    logic [USER_WIDTH-1:0]   m_user_q;

    logic [LANES_P2-1:0]     w_cand;
    logic [IDX_W:0]          w_probe;
    logic                    w_search_hit;
    logic [IDX_W-1:0]        w_search_idx;
    logic                    w_gnt_vld;
    logic [IDX_W-1:0]        w_gnt;
    logic                    w_room;
    logic                    w_accept;

    logic                    w_sel_valid;
    logic [DATA_WIDTH-1:0]   w_sel_data;
    logic [STRB_W-1:0]       w_sel_strb;
    logic [STRB_W-1:0]       w_sel_keep;
    logic                    w_sel_last;
    logic [ID_WIDTH-1:0]     w_sel_id;
    logic [DEST_WIDTH-1:0]   w_sel_dest;
    logic [USER_WIDTH-1:0]   w_sel_user;

    // Search from the lane after the last winner, wrapping modulo N_PORT.
    always_comb begin
        w_cand               = '0;
        w_cand[N_PORT-1:0]   = s_valid_i & port_en_i;
        w_search_hit         = 1'b0;
        w_search_idx         = '0;
        w_probe              = '0;
        for (int k = 1; k <= N_PORT; k++) begin
            w_probe = {1'b0, grant_q} + (IDX_W+1)'(k);
            if (w_probe >= (IDX_W+1)'(N_PORT)) begin
                w_probe = w_probe - (IDX_W+1)'(N_PORT);
            end
            if (!w_search_hit && w_cand[w_probe[IDX_W-1:0]]) begin
                w_search_hit = 1'b1;
                w_search_idx = w_probe[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        if (state_q == ST_LOCKED) begin
            w_gnt     = grant_q;
            w_gnt_vld = 1'b1;
        end else begin
            w_gnt     = w_search_idx;
            w_gnt_vld = w_search_hit;
        end
    end

    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_data  = '0;
        w_sel_strb  = '0;
        w_sel_keep  = '0;
        w_sel_last  = 1'b0;
        w_sel_id    = '0;
        w_sel_dest  = '0;
        w_sel_user  = '0;
        for (int i = 0; i < N_PORT; i++) begin
            if (w_gnt == IDX_W'(i)) begin
                w_sel_valid = s_valid_i[i];
                w_sel_data  = s_data_i[i*DATA_WIDTH +: DATA_WIDTH];
                w_sel_strb  = s_strb_i[i*STRB_W +: STRB_W];
                w_sel_keep  = s_keep_i[i*STRB_W +: STRB_W];
                w_sel_last  = s_last_i[i];
                w_sel_id    = s_id_i[i*ID_WIDTH +: ID_WIDTH];
                w_sel_dest  = s_dest_i[i*DEST_WIDTH +: DEST_WIDTH];
                w_sel_user  = s_user_i[i*USER_WIDTH +: USER_WIDTH];
            end
        end
    end

    // No skid buffer: the granted lane sees output backpressure directly.
    assign w_room   = !m_valid_q || m_ready_i;
    assign w_accept = !rst && w_gnt_vld && w_room && w_sel_valid;

    always_comb begin
        s_ready_o = '0;
        for (int i = 0; i < N_PORT; i++) begin
            s_ready_o[i] = !rst && w_gnt_vld && w_room && (w_gnt == IDX_W'(i));
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        m_valid_d = m_valid_q;
        if (w_accept) begin
            m_valid_d = 1'b1;
            if (state_q == ST_IDLE) begin
                grant_d = w_gnt;
                if (!w_sel_last) begin
                    state_d = ST_LOCKED;
                end
            end else if (w_sel_last) begin
                state_d = ST_IDLE;
            end
        end else if (m_ready_i) begin
            m_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            grant_q   <= LAST_LANE;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_strb_q  <= '0;
            m_keep_q  <= '0;
            m_last_q  <= 1'b0;
            m_id_q    <= '0;
            m_dest_q  <= '0;
            m_user_q  <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            m_valid_q <= m_valid_d;
            if (w_accept) begin
                m_data_q <= w_sel_data;
                m_strb_q <= w_sel_strb;
                m_keep_q <= w_sel_keep;
                m_last_q <= w_sel_last;
                m_id_q   <= w_sel_id;
                m_dest_q <= w_sel_dest;
                m_user_q <= w_sel_user;
            end
        end
    end

    assign m_valid_o   = m_valid_q;
    assign m_data_o    = m_data_q;
    assign m_strb_o    = m_strb_q;
    assign m_keep_o    = m_keep_q;
    assign m_last_o    = m_last_q;
    assign m_id_o      = m_id_q;
    assign m_dest_o    = m_dest_q;
    assign m_user_o    = m_user_q;
    assign grant_idx_o = grant_q;
    assign locked_o    = (state_q == ST_LOCKED);

endmodule
`default_nettype wire

// File: tb/tb_nasti_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_nasti_stream_arbiter
// Brief    : Randomised scoreboard bench for nasti_stream_arbiter.
// Revision : 1.0
// ============================================================================
module tb_nasti_stream_arbiter;

    localparam int N   = 4;
    localparam int DW  = 64;
    localparam int IW  = 8;
    localparam int DSW = 4;
    localparam int UW  = 8;
    localparam int SW  = DW / 8;
    localparam int XW  = 2;

    typedef struct packed {
        logic [DW-1:0]  data;
        logic [SW-1:0]  strb;
        logic [SW-1:0]  keep;
        logic           last;
        logic [IW-1:0]  id;
        logic [DSW-1:0] dest;
        logic [UW-1:0]  user;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0]     port_en, s_valid, s_ready, s_last;
    logic [N*DW-1:0]  s_data;
    logic [N*SW-1:0]  s_strb, s_keep;
    logic [N*IW-1:0]  s_id;
    logic [N*DSW-1:0] s_dest;
    logic [N*UW-1:0]  s_user;
    logic             m_valid, m_ready, m_last, locked;
    logic [DW-1:0]    m_data;
    logic [SW-1:0]    m_strb, m_keep;
    logic [IW-1:0]    m_id;
    logic [DSW-1:0]   m_dest;
    logic [UW-1:0]    m_user;
    logic [XW-1:0]    grant_idx;

    nasti_stream_arbiter #(
        .N_PORT(N), .DATA_WIDTH(DW), .ID_WIDTH(IW), .DEST_WIDTH(DSW), .USER_WIDTH(UW)
    ) dut (
        .clk(clk), .rst(rst), .port_en_i(port_en),
        .s_valid_i(s_valid), .s_ready_o(s_ready), .s_data_i(s_data),
        .s_strb_i(s_strb), .s_keep_i(s_keep), .s_last_i(s_last),
        .s_id_i(s_id), .s_dest_i(s_dest), .s_user_i(s_user),
        .m_valid_o(m_valid), .m_ready_i(m_ready), .m_data_o(m_data),
        .m_strb_o(m_strb), .m_keep_o(m_keep), .m_last_o(m_last),
        .m_id_o(m_id), .m_dest_o(m_dest), .m_user_o(m_user),
        .grant_idx_o(grant_idx), .locked_o(locked)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Stimulus knobs
    logic [N-1:0] active = '1;
    int len_min = 2, len_max = 2, gap_pct = 0, mready_pct = 100;
    bit pen_rand = 0;
    logic [N-1:0] pen_val = '1;

    // Per-lane sources
    bit    pend [N];
    int    beat_no [N];
    int    plen [N];
    beat_t cur [N];

    // Scoreboard and observation
    beat_t exp_q[$];
    int    rec [8];
    int    rec_n = 0;
    bit    pen_phase = 0;
    int    lane1_cnt = 0;

    // Driver: sources advance on handshake, new inputs applied after the edge
    initial begin
        for (int i = 0; i < N; i++) begin
            pend[i] = 0; beat_no[i] = 0; plen[i] = 1; cur[i] = '0;
        end
        s_valid = '0; s_last = '0; s_data = '0; s_strb = '0; s_keep = '0;
        s_id = '0; s_dest = '0; s_user = '0; port_en = '1; m_ready = 1'b1;
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (rst) begin
                    pend[i] = 0; beat_no[i] = 0;
                end else if (s_valid[i] && s_ready[i]) begin
                    pend[i] = 0;
                    beat_no[i] = cur[i].last ? 0 : beat_no[i] + 1;
                end
            end
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && (beat_no[i] != 0 || active[i]) &&
                    $urandom_range(0, 99) >= gap_pct) begin
                    if (beat_no[i] == 0) plen[i] = $urandom_range(len_min, len_max);
                    cur[i].data = {$urandom, $urandom};
                    cur[i].strb = SW'($urandom);
                    cur[i].keep = SW'($urandom);
                    cur[i].last = (beat_no[i] == plen[i] - 1);
                    cur[i].id   = IW'(i);
                    cur[i].dest = DSW'($urandom);
                    cur[i].user = UW'($urandom);
                    pend[i] = 1;
                end
                s_valid[i]          = pend[i];
                s_last[i]           = cur[i].last;
                s_data[i*DW +: DW]  = cur[i].data;
                s_strb[i*SW +: SW]  = cur[i].strb;
                s_keep[i*SW +: SW]  = cur[i].keep;
                s_id[i*IW +: IW]    = cur[i].id;
                s_dest[i*DSW +: DSW]= cur[i].dest;
                s_user[i*UW +: UW]  = cur[i].user;
            end
            port_en = pen_rand ? N'($urandom) : pen_val;
            m_ready = ($urandom_range(0, 99) < mready_pct);
        end
    end

    // Reference model: packet-level round robin with a one-deep output register
    bit m_lock = 0;
    int m_ptr = N - 1;
    bit exp_mv = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_s_ready", s_ready, '0);
                m_lock = 0; m_ptr = N - 1; exp_mv = 0;
                exp_q.delete();
            end else begin
                bit have, room, acc;
                int g;
                logic [N-1:0] er;
                beat_t b;
                chk("m_valid", m_valid, exp_mv);
                chk("locked", locked, m_lock);
                chk("grant_idx", grant_idx, m_ptr);
                room = !exp_mv || m_ready;
                have = 0; g = 0;
                if (m_lock) begin
                    have = 1; g = m_ptr;
                end else begin
                    for (int k = 1; k <= N; k++) begin
                        int c;
                        c = (m_ptr + k) % N;
                        if (!have && s_valid[c] && port_en[c]) begin
                            have = 1; g = c;
                        end
                    end
                end
                er = '0;
                if (have && room) er[g] = 1'b1;
                chk("s_ready", s_ready, er);
                acc = have && room && s_valid[g];
                if (acc) begin
                    b.data = s_data[g*DW +: DW];
                    b.strb = s_strb[g*SW +: SW];
                    b.keep = s_keep[g*SW +: SW];
                    b.last = s_last[g];
                    b.id   = s_id[g*IW +: IW];
                    b.dest = s_dest[g*DSW +: DSW];
                    b.user = s_user[g*UW +: UW];
                    exp_q.push_back(b);
                    if (!m_lock) begin
                        m_ptr = g;
                        m_lock = !b.last;
                    end else if (b.last) begin
                        m_lock = 0;
                    end
                end
                exp_mv = acc ? 1'b1 : (m_ready ? 1'b0 : exp_mv);
            end
        end
    end

    // Monitor: every presented output beat must match the scoreboard head
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && m_valid) begin
                if (exp_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL out_unexpected: got beat id %0h expected none", m_id);
                end else begin
                    beat_t got, e;
                    got = {m_data, m_strb, m_keep, m_last, m_id, m_dest, m_user};
                    chk("out_beat", got, exp_q[0]);
                    if (m_ready) begin
                        e = exp_q.pop_front();
                        if (rec_n < 8) begin
                            rec[rec_n] = int'(e.id);
                            rec_n++;
                        end
                        if (pen_phase && e.id == IW'(1)) lane1_cnt++;
                    end
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic quiesce();
        bit done;
        active = '0; mready_pct = 100; pen_rand = 0; pen_val = '1;
        done = 0;
        for (int c = 0; c < 400 && !done; c++) begin
            @(posedge clk);
            done = 1;
            for (int i = 0; i < N; i++) if (pend[i] || beat_no[i] != 0) done = 0;
            if (exp_q.size() != 0 || m_valid) done = 0;
        end
        #1;
        chk("quiesce_done", done, 1'b1);
    endtask

    initial begin
        // Reset with every lane requesting, then fixed 2-beat round robin
        active = '1; len_min = 2; len_max = 2; gap_pct = 0; mready_pct = 100;
        rst = 1'b1;
        cycles(2);
        rst = 1'b0;
        cycles(40);
        chk("rr_count", rec_n, 8);
        for (int k = 0; k < 8; k++) chk("rr_order", rec[k], k / 2);

        // Random traffic with a forced backpressure stall
        len_min = 1; len_max = 5; gap_pct = 30; mready_pct = 70;
        cycles(300);
        mready_pct = 0;
        cycles(3);
        mready_pct = 70;
        cycles(200);
        quiesce();

        // Lane 1 disabled while requesting
        active = '1; len_min = 1; len_max = 4; gap_pct = 20; mready_pct = 80;
        pen_val = 4'b1101; pen_phase = 1;
        cycles(200);
        pen_phase = 0;
        chk("lane1_blocked", lane1_cnt, 0);
        pen_val = '1;
        cycles(20);

        // Enables toggling underneath packets in flight
        pen_rand = 1;
        cycles(300);
        pen_rand = 0;
        quiesce();

        // Single-beat packets on lanes 0 and 1
        active = 4'b0011; len_min = 1; len_max = 1; gap_pct = 0; mready_pct = 100;
        cycles(30);
        quiesce();

        // Reset in the middle of 4-beat packets
        active = '1; len_min = 4; len_max = 4; gap_pct = 0; mready_pct = 100;
        cycles(6);
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        len_min = 1; len_max = 5; gap_pct = 25; mready_pct = 75;
        cycles(200);
        quiesce();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
